ddr_rd_checker: RTL and testbench

Read-data checker on the `rd_clk` side of the DDR3 AXI test path. It consumes the byte stream returned by the AXI read master (`rd_data_out` / `rd_valid_out` / `rd_data_busy`) after each `rd_begin`. It compares every beat against the incrementing pattern the test generator writes, then reports per-run pass/fail, error count, first-mismatch details and running totals for LEDs or ILA.

---
 rtl/ddr_chk_pkg.sv | 22 ++
 rtl/ddr_chk_pattern_gen.sv | 23 ++
 rtl/ddr_rd_checker.sv | 137 +++++++++++++
 tb/tb_ddr_rd_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_chk_pkg.sv
// ddr_chk_pkg: state encoding, default parameters and helpers shared by the
// ddr_rd_checker read-data checker.
package ddr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    localparam logic [7:0]  DEF_SEED    = 8'h01;
    localparam int unsigned DEF_EXP_LEN = 256;
    localparam int unsigned DEF_TIMEOUT = 4095;
    localparam int unsigned DEF_ERR_W   = 16;

    // Saturating increment; callers pass the all-ones value of their counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/ddr_chk_pattern_gen.sv
// ddr_chk_pattern_gen: expected-byte generator for the incrementing test pattern.
module ddr_chk_pattern_gen
    import ddr_chk_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_SEED
) (
    input  logic       rd_clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       adv,
    output logic [7:0] exp_byte
);

    always_ff @(posedge rd_clk) begin
        if (!rst_n)
            exp_byte <= 8'h00;
        else if (load)
            exp_byte <= SEED;
        else if (adv)
            exp_byte <= exp_byte + 8'd1;
    end

endmodule

// File: rtl/ddr_rd_checker.sv
// ddr_rd_checker: checks AXI read bytes against the incrementing write pattern.
// Optional run timeout enabled by defining DDR_CHK_TIMEOUT_EN.
module ddr_rd_checker
    import ddr_chk_pkg::*;
#(
    parameter int unsigned EXP_LEN = DEF_EXP_LEN,
    parameter logic [7:0]  SEED    = DEF_SEED,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned ERR_W   = DEF_ERR_W
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic             rd_begin,
    input  logic             rd_data_busy,
    input  logic             rd_valid_out,
    input  logic [7:0]       rd_data_out,
    output logic             chk_busy,
    output logic             chk_done,
    output logic             chk_pass,
    output logic             len_err,
    output logic             tmo_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      beat_cnt,
    output logic [15:0]      first_err_idx,
    output logic [7:0]       first_err_data,
    output logic [7:0]       first_err_exp,
    output logic [ERR_W-1:0] run_cnt,
    output logic [ERR_W-1:0] fail_cnt
);

    localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

    chk_state_e state;
    logic       busy_q;
    logic       fin;
    logic [7:0] exp_byte;
    logic       start;
    logic       open;
    logic       beat;
    logic       mism;
    logic       fall;
    logic       tmo_hit;
    logic       end_run;
    logic       pass;

    // fin marks the cycle between seeing busy fall and entering DONE, so a beat
    // arriving with the falling edge is already in beat_cnt when results latch.
    assign start   = rd_begin && (state == IDLE || state == DONE);
    assign open    = (state == ARMED || state == CHECK) && !fin;
    assign beat    = open && rd_valid_out;
    assign mism    = beat && (rd_data_out != exp_byte);
    assign fall    = open && (state == CHECK) && busy_q && !rd_data_busy;
    assign end_run = fin || tmo_hit;
    assign pass    = (err_cnt == '0) && (beat_cnt == 16'(EXP_LEN)) && !tmo_hit;

`ifdef DDR_CHK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    always_ff @(posedge rd_clk) begin
        if (!rst_n || start || beat)
            tmo_cnt <= '0;
        else if (open)
            tmo_cnt <= tmo_cnt + TW'(1);
    end
    // The rd_begin cycle and the registered DONE entry make up the other two cycles.
    assign tmo_hit = open && !rd_valid_out && (tmo_cnt == TW'(TIMEOUT - 2));
`else
    assign tmo_hit = 1'b0;
`endif

    ddr_chk_pattern_gen #(.SEED(SEED)) u_pat (
        .rd_clk   (rd_clk),
        .rst_n    (rst_n),
        .load     (start),
        .adv      (beat),
        .exp_byte (exp_byte)
    );

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            fin            <= 1'b0;
            chk_busy       <= 1'b0;
            chk_done       <= 1'b0;
            chk_pass       <= 1'b0;
            len_err        <= 1'b0;
            tmo_err        <= 1'b0;
            err_cnt        <= '0;
            beat_cnt       <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            run_cnt        <= '0;
            fail_cnt       <= '0;
        end else begin
            busy_q   <= rd_data_busy;
            chk_done <= end_run;
            fin      <= fall && !tmo_hit;
            if (start) begin
                state          <= ARMED;
                chk_busy       <= 1'b1;
                len_err        <= 1'b0;
                tmo_err        <= 1'b0;
                err_cnt        <= '0;
                beat_cnt       <= '0;
                first_err_idx  <= '0;
                first_err_data <= '0;
                first_err_exp  <= '0;
            end else if (end_run) begin
                state    <= DONE;
                len_err  <= beat_cnt != 16'(EXP_LEN);
                tmo_err  <= tmo_hit;
                chk_pass <= pass;
                run_cnt  <= ERR_W'(sat_inc(32'(run_cnt), ERR_MAX));
                if (!pass)
                    fail_cnt <= ERR_W'(sat_inc(32'(fail_cnt), ERR_MAX));
            end else begin
                if (state == ARMED && (rd_valid_out || (rd_data_busy && !busy_q)))
                    state <= CHECK;
                if (state == DONE)
                    chk_busy <= 1'b0;
                if (beat)
                    beat_cnt <= beat_cnt + 16'd1;
                if (mism) begin
                    err_cnt <= ERR_W'(sat_inc(32'(err_cnt), ERR_MAX));
                    if (err_cnt == '0) begin
                        first_err_idx  <= beat_cnt;
                        first_err_data <= rd_data_out;
                        first_err_exp  <= exp_byte;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr_rd_checker.sv
// tb_ddr_rd_checker: table-driven and randomized self-checking bench for ddr_rd_checker.
module tb_ddr_rd_checker;

    localparam int unsigned EXP_LEN_P = 256;
    localparam logic [7:0]  SEED_P    = 8'h01;
    localparam int unsigned TMO_P     = 50;
    localparam int unsigned ERR_W_P   = 16;

    logic                 rd_clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rd_begin = 1'b0;
    logic                 rd_data_busy = 1'b0;
    logic                 rd_valid_out = 1'b0;
    logic [7:0]           rd_data_out = 8'h00;
    logic                 chk_busy, chk_done, chk_pass, len_err, tmo_err;
    logic [ERR_W_P-1:0]   err_cnt, run_cnt, fail_cnt;
    logic [15:0]          beat_cnt, first_err_idx;
    logic [7:0]           first_err_data, first_err_exp;

    int total = 0;
    int bad = 0;

    logic [7:0] stim[$];
    int   m_run, m_fail, m_err, m_idx;
    logic [7:0] m_dat, m_exp;
    bit   m_len, m_pass;

    typedef struct {
        int         n;
        int         bad_idx;
        logic [7:0] bad_val;
        bit         fwl;
        bit         x_pass;
        int         x_err;
        int         x_idx;
        logic [7:0] x_dat;
        logic [7:0] x_exp;
        bit         x_len;
    } vec_t;
    vec_t vt[8];

    ddr_rd_checker #(
        .EXP_LEN (EXP_LEN_P),
        .SEED    (SEED_P),
        .TIMEOUT (TMO_P),
        .ERR_W   (ERR_W_P)
    ) dut (
        .rd_clk         (rd_clk),
        .rst_n          (rst_n),
        .rd_begin       (rd_begin),
        .rd_data_busy   (rd_data_busy),
        .rd_valid_out   (rd_valid_out),
        .rd_data_out    (rd_data_out),
        .chk_busy       (chk_busy),
        .chk_done       (chk_done),
        .chk_pass       (chk_pass),
        .len_err        (len_err),
        .tmo_err        (tmo_err),
        .err_cnt        (err_cnt),
        .beat_cnt       (beat_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data),
        .first_err_exp  (first_err_exp),
        .run_cnt        (run_cnt),
        .fail_cnt       (fail_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_busy"}, chk_busy, 0);
        check({nm, "_done"}, chk_done, 0);
        check({nm, "_pass"}, chk_pass, 0);
        check({nm, "_len"}, len_err, 0);
        check({nm, "_tmo"}, tmo_err, 0);
        check({nm, "_err"}, err_cnt, 0);
        check({nm, "_beats"}, beat_cnt, 0);
        check({nm, "_fidx"}, first_err_idx, 0);
        check({nm, "_fdat"}, first_err_data, 0);
        check({nm, "_fexp"}, first_err_exp, 0);
        check({nm, "_runs"}, run_cnt, 0);
        check({nm, "_fails"}, fail_cnt, 0);
    endtask

    task automatic do_reset();
        rst_n = 0; rd_begin = 0; rd_data_busy = 0; rd_valid_out = 0;
        tick();
        tick();
        rst_n = 1;
        m_run = 0;
        m_fail = 0;
    endtask

    // Reference: expected byte for beat i is SEED + i mod 256.
    task automatic model();
        logic [7:0] e;
        m_err = 0; m_idx = 0; m_dat = 0; m_exp = 0;
        for (int i = 0; i < stim.size(); i++) begin
            e = 8'((int'(SEED_P) + i) % 256);
            if (stim[i] != e) begin
                if (m_err == 0) begin
                    m_idx = i; m_dat = stim[i]; m_exp = e;
                end
                m_err++;
            end
        end
        m_len  = stim.size() != int'(EXP_LEN_P);
        m_pass = (m_err == 0) && !m_len;
        m_run++;
        if (!m_pass) m_fail++;
    endtask

    task automatic build(input int n, input int bad_idx, input logic [7:0] bad_val);
        stim.delete();
        for (int i = 0; i < n; i++)
            stim.push_back(i == bad_idx ? bad_val : 8'((int'(SEED_P) + i) % 256));
    endtask

    // Ends in the chk_done cycle so a following run's rd_begin coincides with it.
    task automatic drive_run(input bit fwl, input int gap_max);
        int n;
        n = stim.size();
        rd_begin = 1;
        tick();
        rd_begin = 0;
        check("start_done_low", chk_done, 0);
        check("start_busy", chk_busy, 1);
        check("start_beats", beat_cnt, 0);
        check("start_errs", err_cnt, 0);
        rd_data_busy = 1;
        tick();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            rd_valid_out = 1;
            rd_data_out = stim[i];
            if (fwl && i == n - 1) rd_data_busy = 0;
            tick();
            rd_valid_out = 0;
            check("beat_cnt_live", beat_cnt, 32'(i + 1));
        end
        rd_data_busy = 0;
        if (!(fwl && n > 0)) tick();
        check("done_not_yet", chk_done, 0);
        tick();
        model();
        check("done", chk_done, 1);
        check("done_busy", chk_busy, 1);
        check("pass", chk_pass, 32'(m_pass));
        check("err_cnt", err_cnt, 32'(m_err));
        check("beat_cnt", beat_cnt, 32'(n));
        check("len_err", len_err, 32'(m_len));
        check("tmo_err", tmo_err, 0);
        check("first_idx", first_err_idx, 32'(m_idx));
        check("first_dat", first_err_data, 32'(m_dat));
        check("first_exp", first_err_exp, 32'(m_exp));
        check("run_cnt", run_cnt, 32'(m_run));
        check("fail_cnt", fail_cnt, 32'(m_fail));
    endtask

    initial begin
        vt[0] = '{256, -1,  8'h00, 1'b0, 1'b1, 0, 0,   8'h00, 8'h00, 1'b0};
        vt[1] = '{256, 10,  8'h00, 1'b0, 1'b0, 1, 10,  8'h00, 8'h0B, 1'b0};
        vt[2] = '{200, -1,  8'h00, 1'b0, 1'b0, 0, 0,   8'h00, 8'h00, 1'b1};
        vt[3] = '{256, -1,  8'h00, 1'b1, 1'b1, 0, 0,   8'h00, 8'h00, 1'b0};
        vt[4] = '{300, -1,  8'h00, 1'b0, 1'b0, 0, 0,   8'h00, 8'h00, 1'b1};
        vt[5] = '{256, 255, 8'h55, 1'b1, 1'b0, 1, 255, 8'h55, 8'h00, 1'b0};
        vt[6] = '{0,   -1,  8'h00, 1'b0, 1'b0, 0, 0,   8'h00, 8'h00, 1'b1};
        vt[7] = '{1,   0,   8'h02, 1'b0, 1'b0, 1, 0,   8'h02, 8'h01, 1'b1};

        do_reset();
        check_zero("reset");

        foreach (vt[k]) begin
            build(vt[k].n, vt[k].bad_idx, vt[k].bad_val);
            drive_run(vt[k].fwl, k % 3);
            check("vec_pass", chk_pass, 32'(vt[k].x_pass));
            check("vec_err", err_cnt, 32'(vt[k].x_err));
            check("vec_idx", first_err_idx, 32'(vt[k].x_idx));
            check("vec_dat", first_err_data, 32'(vt[k].x_dat));
            check("vec_exp", first_err_exp, 32'(vt[k].x_exp));
            check("vec_len", len_err, 32'(vt[k].x_len));
        end

        // Results hold and busy drops once the run is over.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_busy", chk_busy, 0);
            check("idle_done", chk_done, 0);
            check("idle_pass", chk_pass, 32'(m_pass));
            check("idle_beats", beat_cnt, 32'(stim.size()));
        end

`ifdef DDR_CHK_TIMEOUT_EN
        begin
            int c;
            rd_begin = 1;
            tick();
            rd_begin = 0;
            c = 1;
            while (!chk_done && c < int'(TMO_P) + 20) begin
                tick();
                c++;
            end
            m_run++;
            m_fail++;
            check("tmo_latency", c, TMO_P);
            check("tmo_err_set", tmo_err, 1);
            check("tmo_pass", chk_pass, 0);
            check("tmo_beats", beat_cnt, 0);
            check("tmo_runs", run_cnt, 32'(m_run));
            check("tmo_fails", fail_cnt, 32'(m_fail));
        end
`endif

        // Reset in the middle of a run; a stray rd_begin mid-run is ignored.
        build(256, -1, 8'h00);
        rd_begin = 1;
        tick();
        rd_begin = 0;
        rd_data_busy = 1;
        tick();
        for (int i = 0; i < 100; i++) begin
            rd_valid_out = 1;
            rd_data_out = stim[i];
            rd_begin = (i == 50);
            tick();
        end
        rd_begin = 0;
        check("ignored_begin", beat_cnt, 100);
        rd_data_out = stim[100];
        rst_n = 0;
        tick();
        check_zero("midrst");
        rst_n = 1;
        rd_valid_out = 0;
        rd_data_busy = 0;
        m_run = 0;
        m_fail = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", chk_done, 0);
        end
        drive_run(1'b0, 0);
        check("after_rst_runs", run_cnt, 1);
        check("after_rst_pass", chk_pass, 1);

        // Three chained runs, the middle one corrupted.
        do_reset();
        build(256, -1, 8'h00);
        drive_run(1'b0, 1);
        build(256, 50, 8'hEE);
        drive_run(1'b1, 1);
        build(256, -1, 8'h00);
        drive_run(1'b0, 1);
        check("b2b_runs", run_cnt, 3);
        check("b2b_fails", fail_cnt, 1);
        check("b2b_pass", chk_pass, 1);

        for (int r = 0; r < 30; r++) begin
            int n;
            n = (r % 5 == 0) ? int'(EXP_LEN_P) : int'($urandom_range(1, 300));
            build(n, -1, 8'h00);
            for (int i = 0; i < n; i++)
                if ($urandom_range(0, 19) == 0) stim[i] = 8'($urandom_range(0, 255));
            drive_run(1'($urandom_range(0, 1)), 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
